// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM states,
// requester ids and the ALU opcode map used by the execute path.
package alu_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_t;

    localparam logic REQ_EXEC = 1'b0;
    localparam logic REQ_ADDR = 1'b1;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SHL  = 3'b101;
    localparam logic [2:0] ALU_SHR  = 3'b110;
    localparam logic [2:0] ALU_PASS = 3'b111;

    function automatic logic [1:0] onehot_id(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Two-way grant logic: round-robin on last_grant or fixed priority to
// the execute stage. Grant is combinational; last_grant moves on accept.
module alu_arbiter_rr_arbiter2
    import alu_arbiter_pkg::*;
#(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [1:0] valid,
    input  logic       update,
    output logic [1:0] grant
);

    logic       last_grant_r;
    logic [1:0] grant_s;

    // Pick at most one valid requester while the arbiter is open
    always_comb begin
        grant_s = 2'b00;
        if (enable) begin
            case (valid)
                2'b01:   grant_s = 2'b01;
                2'b10:   grant_s = 2'b10;
                2'b11: begin
                    if (RR_ENABLE) begin
                        grant_s = onehot_id(~last_grant_r);
                    end else begin
                        grant_s = onehot_id(REQ_EXEC);
                    end
                end
                default: grant_s = 2'b00;
            endcase
        end else begin
            grant_s = 2'b00;
        end
    end

    // Remember who was served last so contention alternates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= REQ_ADDR;
        end else if (update) begin
            last_grant_r <= grant_s[1];
        end
    end

    assign grant = grant_s;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the execute stage (id 0) and the
// address/PC unit (id 1): accept, issue for one cycle, hold the response.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OP_WIDTH   = 3,
    parameter bit RR_ENABLE  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    input  logic                  req1_valid,
    output logic                  req0_ready,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req0_op1,
    input  logic [DATA_WIDTH-1:0] req0_op2,
    input  logic [DATA_WIDTH-1:0] req1_op1,
    input  logic [DATA_WIDTH-1:0] req1_op2,
    input  logic [OP_WIDTH-1:0]   req0_op,
    input  logic [OP_WIDTH-1:0]   req1_op,
    output logic [DATA_WIDTH-1:0] alu_operand1,
    output logic [DATA_WIDTH-1:0] alu_operand2,
    output logic [OP_WIDTH-1:0]   alu_op,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero_flag,
    input  logic                  alu_overflow_flag,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_zero,
    output logic                  rsp_overflow,
    output logic                  busy
);

    arb_state_t            state_r;
    logic [DATA_WIDTH-1:0] op1_r;
    logic [DATA_WIDTH-1:0] op2_r;
    logic [OP_WIDTH-1:0]   aop_r;
    logic                  id_r;
    logic                  rsp_valid_r;
    logic [DATA_WIDTH-1:0] rsp_result_r;
    logic                  rsp_zero_r;
    logic                  rsp_overflow_r;

    logic                  open_s;
    logic [1:0]            grant_s;
    logic                  accept_s;
    logic                  sel_id_s;
    logic [DATA_WIDTH-1:0] sel_op1_s;
    logic [DATA_WIDTH-1:0] sel_op2_s;
    logic [OP_WIDTH-1:0]   sel_op_s;

    // rst_n gates the grant so readies read 0 for the whole reset window
    assign open_s = (state_r == ST_IDLE) && rst_n;

    alu_arbiter_rr_arbiter2 #(
        .RR_ENABLE (RR_ENABLE)
    ) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (open_s),
        .valid  ({req1_valid, req0_valid}),
        .update (accept_s),
        .grant  (grant_s)
    );

    // A grant is only ever given to a valid requester, so any grant is an accept
    assign accept_s = |grant_s;

    // Route the granted requester's payload toward the drive registers
    always_comb begin
        sel_id_s = grant_s[1];
        if (grant_s[1]) begin
            sel_op1_s = req1_op1;
            sel_op2_s = req1_op2;
            sel_op_s  = req1_op;
        end else begin
            sel_op1_s = req0_op1;
            sel_op2_s = req0_op2;
            sel_op_s  = req0_op;
        end
    end

    // Accept, issue and response-hold sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            op1_r          <= {DATA_WIDTH{1'b0}};
            op2_r          <= {DATA_WIDTH{1'b0}};
            aop_r          <= {OP_WIDTH{1'b0}};
            id_r           <= 1'b0;
            rsp_valid_r    <= 1'b0;
            rsp_result_r   <= {DATA_WIDTH{1'b0}};
            rsp_zero_r     <= 1'b0;
            rsp_overflow_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op1_r   <= sel_op1_s;
                        op2_r   <= sel_op2_s;
                        aop_r   <= sel_op_s;
                        id_r    <= sel_id_s;
                        state_r <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    rsp_result_r   <= alu_result;
                    rsp_zero_r     <= alu_zero_flag;
                    rsp_overflow_r <= alu_overflow_flag;
                    rsp_valid_r    <= 1'b1;
                    state_r        <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req0_ready   = grant_s[0];
    assign req1_ready   = grant_s[1];
    assign alu_operand1 = op1_r;
    assign alu_operand2 = op2_r;
    assign alu_op       = aop_r;
    assign rsp_valid    = rsp_valid_r;
    assign rsp_id       = id_r;
    assign rsp_result   = rsp_result_r;
    assign rsp_zero     = rsp_zero_r;
    assign rsp_overflow = rsp_overflow_r;
    assign busy         = (state_r != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a round-robin instance under directed
// and random traffic, plus a fixed-priority instance for ordering.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    typedef struct packed {
        logic       id;
        logic [7:0] res;
        logic       z;
        logic       o;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [7:0] req0_op1, req0_op2, req1_op1, req1_op2;
    logic [2:0] req0_op, req1_op;
    logic [7:0] alu_operand1, alu_operand2, alu_result;
    logic [2:0] alu_op;
    logic       alu_zero_flag, alu_overflow_flag;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_overflow, busy;
    logic [7:0] rsp_result;

    logic       fp_req0_valid, fp_req1_valid, fp_req0_ready, fp_req1_ready;
    logic [7:0] fp_req0_op1, fp_req0_op2, fp_req1_op1, fp_req1_op2;
    logic [2:0] fp_req0_op, fp_req1_op;
    logic [7:0] fp_alu_operand1, fp_alu_operand2, fp_alu_result;
    logic [2:0] fp_alu_op;
    logic       fp_alu_zero_flag, fp_alu_overflow_flag;
    logic       fp_rsp_valid, fp_rsp_ready, fp_rsp_id, fp_rsp_zero, fp_rsp_overflow, fp_busy;
    logic [7:0] fp_rsp_result;

    rsp_t       exp_q[$];
    logic       acc_log[$];
    logic [8:0] fp_log[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    bit         rand_done;

    // Behavioural ALU: {zero, overflow, result}; overflow is signed add/sub overflow
    function automatic logic [9:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic       o;
        r = 8'h00;
        o = 1'b0;
        case (op)
            ALU_ADD: begin r = a + b; o = (a[7] == b[7]) && (r[7] != a[7]); end
            ALU_SUB: begin r = a - b; o = (a[7] != b[7]) && (r[7] != a[7]); end
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_SHL: r = {a[6:0], 1'b0};
            ALU_SHR: r = {1'b0, a[7:1]};
            default: r = b;
        endcase
        return {(r == 8'h00), o, r};
    endfunction

    assign {alu_zero_flag, alu_overflow_flag, alu_result} = alu_f(alu_op, alu_operand1, alu_operand2);
    assign {fp_alu_zero_flag, fp_alu_overflow_flag, fp_alu_result} =
        alu_f(fp_alu_op, fp_alu_operand1, fp_alu_operand2);

    alu_arbiter #(.DATA_WIDTH(8), .OP_WIDTH(3), .RR_ENABLE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_op1(req0_op1), .req0_op2(req0_op2), .req1_op1(req1_op1), .req1_op2(req1_op2),
        .req0_op(req0_op), .req1_op(req1_op),
        .alu_operand1(alu_operand1), .alu_operand2(alu_operand2), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero_flag(alu_zero_flag), .alu_overflow_flag(alu_overflow_flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow), .busy(busy)
    );

    alu_arbiter #(.DATA_WIDTH(8), .OP_WIDTH(3), .RR_ENABLE(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(fp_req0_valid), .req1_valid(fp_req1_valid),
        .req0_ready(fp_req0_ready), .req1_ready(fp_req1_ready),
        .req0_op1(fp_req0_op1), .req0_op2(fp_req0_op2), .req1_op1(fp_req1_op1), .req1_op2(fp_req1_op2),
        .req0_op(fp_req0_op), .req1_op(fp_req1_op),
        .alu_operand1(fp_alu_operand1), .alu_operand2(fp_alu_operand2), .alu_op(fp_alu_op),
        .alu_result(fp_alu_result), .alu_zero_flag(fp_alu_zero_flag), .alu_overflow_flag(fp_alu_overflow_flag),
        .rsp_valid(fp_rsp_valid), .rsp_ready(fp_rsp_ready), .rsp_id(fp_rsp_id), .rsp_result(fp_rsp_result),
        .rsp_zero(fp_rsp_zero), .rsp_overflow(fp_rsp_overflow), .busy(fp_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present one request, hold it until ready, drop valid after the accept edge
    task automatic send(input bit id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        if (id) begin
            req1_op = op; req1_op1 = a; req1_op2 = b; req1_valid = 1'b1;
        end else begin
            req0_op = op; req0_op1 = a; req0_op2 = b; req0_valid = 1'b1;
        end
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            got = id ? req1_ready : req0_ready;
        end
        chk("accept_in_time", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    task automatic fp_send(input bit id, input logic [7:0] a);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        if (id) begin
            fp_req1_op = ALU_ADD; fp_req1_op1 = a; fp_req1_op2 = 8'h03; fp_req1_valid = 1'b1;
        end else begin
            fp_req0_op = ALU_ADD; fp_req0_op1 = a; fp_req0_op2 = 8'h03; fp_req0_valid = 1'b1;
        end
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            got = id ? fp_req1_ready : fp_req0_ready;
        end
        chk("fp_accept_in_time", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        if (id) fp_req1_valid = 1'b0;
        else    fp_req0_valid = 1'b0;
    endtask

    // Wait for the response following an accept and compare with fixed values
    task automatic wait_rsp(input logic id, input logic [7:0] res, input logic z, input logic o);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 20);
        chk("rsp_latency", 32'(n), 32'd2);
        chk("rsp_id", 32'(rsp_id), 32'(id));
        chk("rsp_result", 32'(rsp_result), 32'(res));
        chk("rsp_zero", 32'(rsp_zero), 32'(z));
        chk("rsp_overflow", 32'(rsp_overflow), 32'(o));
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_ready"}, 32'({req0_ready, req1_ready}), 32'd0);
        chk({tag, "_alu"}, 32'({alu_operand1, alu_operand2, alu_op}), 32'd0);
        chk({tag, "_rsp"}, 32'({rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_overflow, busy}), 32'd0);
    endtask

    // Transaction-level model: predicts grants, phase and responses per cycle
    initial begin : monitor
        int   ph;
        logic last;
        logic g0, g1;
        logic [9:0] f;
        rsp_t e, got;
        ph = 0;
        last = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ph = 0;
                last = 1'b1;
                exp_q.delete();
            end else begin
                g0 = 1'b0;
                g1 = 1'b0;
                if (ph == 0) begin
                    if (req0_valid && req1_valid) begin
                        g0 = last;
                        g1 = ~last;
                    end else begin
                        g0 = req0_valid;
                        g1 = req1_valid;
                    end
                end
                if (req0_ready && req0_valid) acc_log.push_back(1'b0);
                if (req1_ready && req1_valid) acc_log.push_back(1'b1);
                chk("busy", 32'(busy), 32'(ph != 0));
                chk("rsp_valid", 32'(rsp_valid), 32'(ph == 2));
                chk("req0_ready", 32'(req0_ready), 32'(g0));
                chk("req1_ready", 32'(req1_ready), 32'(g1));
                if (ph == 0) begin
                    if (g0 || g1) begin
                        f = g1 ? alu_f(req1_op, req1_op1, req1_op2) : alu_f(req0_op, req0_op1, req0_op2);
                        e.id = g1;
                        e.res = f[7:0];
                        e.z = f[9];
                        e.o = f[8];
                        exp_q.push_back(e);
                        last = g1;
                        ph = 1;
                    end
                end else if (ph == 1) begin
                    ph = 2;
                end else if (rsp_ready) begin
                    got = {rsp_id, rsp_result, rsp_zero, rsp_overflow};
                    chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("sb_rsp", 32'(got), 32'(e));
                    end
                    ph = 0;
                end
            end
        end
    end

    initial begin : fp_monitor
        forever begin
            @(negedge clk);
            if (rst_n && fp_rsp_valid && fp_rsp_ready) fp_log.push_back({fp_rsp_id, fp_rsp_result});
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [10:0] snap;
        int n;
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op1 = 8'h00; req0_op2 = 8'h00; req1_op1 = 8'h00; req1_op2 = 8'h00;
        req0_op = 3'b000; req1_op = 3'b000;
        rsp_ready = 1'b1;
        fp_req0_valid = 1'b0; fp_req1_valid = 1'b0;
        fp_req0_op1 = 8'h00; fp_req0_op2 = 8'h00; fp_req1_op1 = 8'h00; fp_req1_op2 = 8'h00;
        fp_req0_op = 3'b000; fp_req1_op = 3'b000;
        fp_rsp_ready = 1'b1;
        rand_done = 1'b0;

        #12;
        check_outputs_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // Signed overflow into the sign bit, then an exact-zero subtract
        send(1'b0, ALU_ADD, 8'h7F, 8'h01);
        wait_rsp(1'b0, 8'h80, 1'b0, 1'b1);
        send(1'b1, ALU_SUB, 8'h05, 8'h05);
        wait_rsp(1'b1, 8'h00, 1'b1, 1'b0);

        // Backpressure with both requesters waiting
        rsp_ready = 1'b0;
        fork
            send(1'b0, ALU_XOR, 8'hA5, 8'h0F);
            send(1'b1, ALU_OR, 8'h30, 8'h03);
            begin
                n = 0;
                do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
                snap = {rsp_id, rsp_result, rsp_zero, rsp_overflow};
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_hold", 32'({rsp_id, rsp_result, rsp_zero, rsp_overflow}), 32'(snap));
                    chk("bp_ready", 32'({req0_ready, req1_ready}), 32'd0);
                end
                @(posedge clk); #1;
                rsp_ready = 1'b1;
            end
        join
        repeat (6) begin @(posedge clk); #1; end

        // Both requesters continuously valid: grants must alternate
        acc_log.delete();
        fork
            begin
                for (int i = 0; i < 4; i++) send(1'b0, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
            end
            begin
                for (int i = 0; i < 4; i++) send(1'b1, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
            end
        join
        chk("rr_count", 32'(acc_log.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < acc_log.size()) chk("rr_order", 32'(acc_log[i]), 32'(i % 2));
        end
        repeat (6) begin @(posedge clk); #1; end

        // req1 raises and withdraws a request while req0's op is in flight
        rsp_ready = 1'b0;
        send(1'b0, ALU_SHL, 8'h81, 8'h00);
        req1_op = ALU_AND; req1_op1 = 8'hEE; req1_op2 = 8'hEE; req1_valid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        send(1'b1, ALU_ADD, 8'h12, 8'h34);
        wait_rsp(1'b1, 8'h46, 1'b0, 1'b0);

        // Random traffic with random response backpressure
        fork
            begin
                fork
                    begin
                        for (int i = 0; i < 15; i++) begin
                            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                            send(1'b0, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
                        end
                    end
                    begin
                        for (int i = 0; i < 15; i++) begin
                            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                            send(1'b1, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
                        end
                    end
                join
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    rsp_ready = 1'($urandom_range(0, 1));
                end
                rsp_ready = 1'b1;
            end
        join
        repeat (8) begin @(posedge clk); #1; end

        // Asynchronous reset while a response is being held
        rsp_ready = 1'b0;
        send(1'b1, ALU_SUB, 8'h80, 8'h01);
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
        chk("pre_reset_rsp_valid", 32'(rsp_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        repeat (5) begin @(posedge clk); #1; end

        // Fixed priority: every execute-stage op completes before any address op
        fork
            begin
                for (int i = 0; i < 4; i++) fp_send(1'b0, 8'(i));
            end
            begin
                for (int i = 0; i < 4; i++) fp_send(1'b1, 8'(8'h10 + i));
            end
        join
        repeat (6) begin @(posedge clk); #1; end
        chk("fp_count", 32'(fp_log.size()), 32'd8);
        for (int j = 0; j < 8; j++) begin
            if (j < fp_log.size()) chk("fp_order", 32'(fp_log[j]), 32'({1'(j / 4), 8'(16 * (j / 4) + (j % 4) + 3)}));
        end

        repeat (5) @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
